// File: rtl/tone_generator_multi.sv
// rtl/tone_generator_multi.sv - time-multiplexed N-voice phase-accumulator tone generator
//
// Optional feature macro: TONE_GENERATOR_MULTI_NOISE_EN (per-voice 23-bit noise LFSRs).
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   sample_tick         one-cycle pulse starting a sweep over all voices
//   cfg_we/cfg_voice/cfg_reg/cfg_data  register write (0 freq, 1 pulse width, 2 control)
//   dout/dout_voice/dout_valid  registered sample of one voice per cycle
//   sweep_done          pulses with the last voice's sample
//   busy                sweep in progress
//   overrun             pulse: sample_tick arrived while busy
module tone_generator_multi #(
    parameter int NUM_VOICES       = 3,
    parameter int FREQ_BITS        = 16,
    parameter int PULSEWIDTH_BITS  = 12,
    parameter int OUTPUT_BITS      = 12,
    parameter int ACCUMULATOR_BITS = 24,
    parameter int NOISE_BIT        = 19
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_tick,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
    input  logic [1:0]                    cfg_reg,
    input  logic [15:0]                   cfg_data,
    output logic [OUTPUT_BITS-1:0]        dout,
    output logic [$clog2(NUM_VOICES)-1:0] dout_voice,
    output logic                          dout_valid,
    output logic                          sweep_done,
    output logic                          busy,
    output logic                          overrun
);
    localparam int VW = $clog2(NUM_VOICES);
    localparam int AW = ACCUMULATOR_BITS;
    localparam int OW = OUTPUT_BITS;
    localparam int PW = PULSEWIDTH_BITS;
    localparam int CW = 6;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                state_q, state_d;
    logic [VW-1:0]         vcnt_q, vcnt_d;
    logic [AW-1:0]         acc_q   [NUM_VOICES];
    logic [AW-1:0]         acc_d   [NUM_VOICES];
    logic [NUM_VOICES-1:0] ovf_q, ovf_d;
    logic [FREQ_BITS-1:0]  freq_q  [NUM_VOICES];
    logic [FREQ_BITS-1:0]  freq_d  [NUM_VOICES];
    logic [PW-1:0]         pw_q    [NUM_VOICES];
    logic [PW-1:0]         pw_d    [NUM_VOICES];
    logic [CW-1:0]         ctrl_q  [NUM_VOICES];
    logic [CW-1:0]         ctrl_d  [NUM_VOICES];
`ifdef TONE_GENERATOR_MULTI_NOISE_EN
    logic [22:0]           lfsr_q  [NUM_VOICES];
    logic [22:0]           lfsr_d  [NUM_VOICES];
    logic [22:0]           lfsr_new;
`endif
    logic [OW-1:0]         dout_q, dout_d;
    logic [VW-1:0]         dout_voice_q, dout_voice_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  sweep_done_q, sweep_done_d;
    logic                  overrun_q, overrun_d;

    // Shared per-voice datapath, always evaluated for the voice under vcnt_q.
    logic [VW-1:0]         src;
    logic [AW:0]           sum;
    logic                  sync_hit;
    logic [AW-1:0]         acc_new;
    logic                  ovf_new;
    logic [CW-1:0]         ctrl_v;
    logic                  tri_inv;
    logic [OW-1:0]         saw_w, tri_w, pulse_w, noise_w, sample;
    logic                  last_voice;
    logic                  cfg_hit;

    always_comb begin
        ctrl_v   = ctrl_q[vcnt_q];
        src      = (vcnt_q == '0) ? VW'(NUM_VOICES - 1) : vcnt_q - VW'(1);
        sum      = {1'b0, acc_q[vcnt_q]} + {{(AW + 1 - FREQ_BITS){1'b0}}, freq_q[vcnt_q]};
        // ovf_q[src] already holds this sweep's carry for v>0, last sweep's for v=0.
        sync_hit = ctrl_v[5] & ovf_q[src];
        acc_new  = sync_hit ? '0 : sum[AW-1:0];
        ovf_new  = sync_hit ? 1'b0 : sum[AW];
        saw_w    = acc_new[AW-1 -: OW];
        tri_inv  = acc_new[AW-1] ^ (ctrl_v[4] & acc_q[src][AW-1]);
        tri_w    = acc_new[AW-2 -: OW] ^ {OW{tri_inv}};
        pulse_w  = (acc_new[AW-1 -: PW] >= pw_q[vcnt_q]) ? {OW{1'b1}} : '0;
`ifdef TONE_GENERATOR_MULTI_NOISE_EN
        lfsr_new = lfsr_q[vcnt_q];
        if (acc_new[NOISE_BIT] && !acc_q[vcnt_q][NOISE_BIT]) begin
            lfsr_new = {lfsr_q[vcnt_q][21:0], lfsr_q[vcnt_q][22] ^ lfsr_q[vcnt_q][17]};
        end
        noise_w  = ctrl_v[0] ? lfsr_new[22 -: OW] : {OW{1'b1}};
`else
        noise_w  = {OW{1'b1}};
`endif
        sample   = noise_w
                 & (ctrl_v[1] ? pulse_w : {OW{1'b1}})
                 & (ctrl_v[2] ? tri_w   : {OW{1'b1}})
                 & (ctrl_v[3] ? saw_w   : {OW{1'b1}});
        last_voice = (vcnt_q == VW'(NUM_VOICES - 1));
        cfg_hit    = cfg_we && ({1'b0, cfg_voice} < (VW + 1)'(NUM_VOICES));
    end

    always_comb begin
        state_d      = state_q;
        vcnt_d       = vcnt_q;
        acc_d        = acc_q;
        ovf_d        = ovf_q;
        freq_d       = freq_q;
        pw_d         = pw_q;
        ctrl_d       = ctrl_q;
`ifdef TONE_GENERATOR_MULTI_NOISE_EN
        lfsr_d       = lfsr_q;
`endif
        dout_d       = dout_q;
        dout_voice_d = dout_voice_q;
        dout_valid_d = 1'b0;
        sweep_done_d = 1'b0;
        overrun_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    state_d = SWEEP;
                    vcnt_d  = '0;
                end
            end
            SWEEP: begin
                overrun_d         = sample_tick;
                acc_d[vcnt_q]     = acc_new;
                ovf_d[vcnt_q]     = ovf_new;
`ifdef TONE_GENERATOR_MULTI_NOISE_EN
                lfsr_d[vcnt_q]    = lfsr_new;
`endif
                dout_d            = sample;
                dout_voice_d      = vcnt_q;
                dout_valid_d      = 1'b1;
                sweep_done_d      = last_voice;
                vcnt_d            = vcnt_q + VW'(1);
                if (last_voice) begin
                    state_d = IDLE;
                    vcnt_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Config fields are disjoint from sweep state, so a same-cycle write
        // to the active voice lands after this update and is seen next sweep.
        if (cfg_hit) begin
            case (cfg_reg)
                2'd0:    freq_d[cfg_voice] = cfg_data[FREQ_BITS-1:0];
                2'd1:    pw_d[cfg_voice]   = cfg_data[PW-1:0];
                2'd2:    ctrl_d[cfg_voice] = cfg_data[CW-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            vcnt_q       <= '0;
            ovf_q        <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                acc_q[i]  <= '0;
                freq_q[i] <= '0;
                pw_q[i]   <= '0;
                ctrl_q[i] <= '0;
`ifdef TONE_GENERATOR_MULTI_NOISE_EN
                lfsr_q[i] <= 23'h7FFFFF;
`endif
            end
            dout_q       <= '0;
            dout_voice_q <= '0;
            dout_valid_q <= 1'b0;
            sweep_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            vcnt_q       <= vcnt_d;
            acc_q        <= acc_d;
            ovf_q        <= ovf_d;
            freq_q       <= freq_d;
            pw_q         <= pw_d;
            ctrl_q       <= ctrl_d;
`ifdef TONE_GENERATOR_MULTI_NOISE_EN
            lfsr_q       <= lfsr_d;
`endif
            dout_q       <= dout_d;
            dout_voice_q <= dout_voice_d;
            dout_valid_q <= dout_valid_d;
            sweep_done_q <= sweep_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_voice = dout_voice_q;
    assign dout_valid = dout_valid_q;
    assign sweep_done = sweep_done_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q == SWEEP);

    logic unused_ok;
    assign unused_ok = ^{cfg_data, ctrl_v[0], sum[AW]};
endmodule
